alu_8_bit: RTL and testbench



---
 rtl/alu_8bit_pkg.sv | 31 +++
 rtl/alu_8bit_comb.sv | 91 +++++++++
 rtl/alu_8_bit.sv | 57 +++++
 tb/tb_alu_8_bit.sv | 135 +++++++++++++
 4 files changed

// File: rtl/alu_8bit_pkg.sv
// Shared types and constants for the registered 8-bit ALU.
// Holds the opcode encoding and the values the output registers take on reset.
package alu_8bit_pkg;

    localparam int unsigned DATA_W = 8;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_NOT  = 4'h5,
        OP_SHL  = 4'h6,
        OP_SHR  = 4'h7,
        OP_ASR  = 4'h8,
        OP_ROL  = 4'h9,
        OP_ROR  = 4'hA,
        OP_INC  = 4'hB,
        OP_DEC  = 4'hC,
        OP_NAND = 4'hD,
        OP_NOR  = 4'hE,
        OP_PASS = 4'hF
    } opcode_e;

    localparam logic [DATA_W-1:0] RST_RESULT   = '0;
    localparam logic              RST_CARRY    = 1'b0;
    localparam logic              RST_ZERO     = 1'b1;
    localparam logic              RST_OVERFLOW = 1'b0;

endpackage

// File: rtl/alu_8bit_comb.sv
// Combinational result and flag computation for the 8-bit ALU.
// Carry and Overflow default to 0, so only the ops that define them ever set them.
module alu_8bit_comb
    import alu_8bit_pkg::*;
(
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic [3:0] i_opcode,
    output logic [7:0] o_result_c,
    output logic       o_carry_c,
    output logic       o_zero_c,
    output logic       o_overflow_c
);

    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_diff;
    logic [DATA_W:0]   w_inc;
    logic [DATA_W-1:0] w_res;
    logic              w_c;
    logic              w_v;
    opcode_e           w_op;

    assign w_op = opcode_e'(i_opcode);

    // Zero-extended 9-bit arithmetic: bit 8 is carry for add and borrow for subtract.
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};
    assign w_inc  = {1'b0, i_a} + 9'd1;

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (w_op)
            OP_ADD: begin
                w_res = w_sum[7:0];
                w_c   = w_sum[8];
                w_v   = (i_a[7] == i_b[7]) && (w_sum[7] != i_a[7]);
            end
            OP_SUB: begin
                w_res = w_diff[7:0];
                w_c   = w_diff[8];
                w_v   = (i_a[7] != i_b[7]) && (w_diff[7] != i_a[7]);
            end
            OP_AND:  w_res = i_a & i_b;
            OP_OR:   w_res = i_a | i_b;
            OP_XOR:  w_res = i_a ^ i_b;
            OP_NOT:  w_res = ~i_a;
            OP_SHL: begin
                w_res = {i_a[6:0], 1'b0};
                w_c   = i_a[7];
            end
            OP_SHR: begin
                w_res = {1'b0, i_a[7:1]};
                w_c   = i_a[0];
            end
            OP_ASR: begin
                w_res = {i_a[7], i_a[7:1]};
                w_c   = i_a[0];
            end
            OP_ROL: begin
                w_res = {i_a[6:0], i_a[7]};
                w_c   = i_a[7];
            end
            OP_ROR: begin
                w_res = {i_a[0], i_a[7:1]};
                w_c   = i_a[0];
            end
            OP_INC: begin
                w_res = w_inc[7:0];
                w_c   = w_inc[8];
                w_v   = (i_a == 8'h7F);
            end
            OP_DEC: begin
                w_res = i_a - 8'd1;
                w_c   = (i_a == 8'h00);
                w_v   = (i_a == 8'h80);
            end
            OP_NAND: w_res = ~(i_a & i_b);
            OP_NOR:  w_res = ~(i_a | i_b);
            OP_PASS: w_res = i_a;
            default: w_res = '0;
        endcase
    end

    assign o_result_c   = w_res;
    assign o_carry_c    = w_c;
    assign o_overflow_c = w_v;
    assign o_zero_c     = (w_res == '0);

endmodule

// File: rtl/alu_8_bit.sv
// Registered 8-bit ALU: one-cycle latency, one operation per cycle, no handshake.
// Synchronous reset takes priority over operands presented in the same cycle.
module alu_8_bit
    import alu_8bit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [3:0] Opcode,
    output logic [7:0] Result,
    output logic       Carry,
    output logic       Zero,
    output logic       Overflow
);

    logic [7:0] w_result;
    logic       w_carry;
    logic       w_zero;
    logic       w_overflow;

    logic [7:0] r_result;
    logic       r_carry;
    logic       r_zero;
    logic       r_overflow;

    alu_8bit_comb u_comb (
        .i_a          (A),
        .i_b          (B),
        .i_opcode     (Opcode),
        .o_result_c   (w_result),
        .o_carry_c    (w_carry),
        .o_zero_c     (w_zero),
        .o_overflow_c (w_overflow)
    );

    // Output stage; flags are recomputed every cycle, never sticky.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result   <= RST_RESULT;
            r_carry    <= RST_CARRY;
            r_zero     <= RST_ZERO;
            r_overflow <= RST_OVERFLOW;
        end else begin
            r_result   <= w_result;
            r_carry    <= w_carry;
            r_zero     <= w_zero;
            r_overflow <= w_overflow;
        end
    end

    assign Result   = r_result;
    assign Carry    = r_carry;
    assign Zero     = r_zero;
    assign Overflow = r_overflow;

endmodule

// File: tb/tb_alu_8_bit.sv
// Self-checking bench for alu_8_bit: reset sequences plus a back-to-back vector table.
module tb_alu_8_bit;
    import alu_8bit_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] A;
    logic [7:0] B;
    logic [3:0] Opcode;
    logic [7:0] Result;
    logic       Carry;
    logic       Zero;
    logic       Overflow;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic       c;
        logic       v;
        logic       z;
    } vec_t;

    vec_t vecs[$];

    alu_8_bit dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .B        (B),
        .Opcode   (Opcode),
        .Result   (Result),
        .Carry    (Carry),
        .Zero     (Zero),
        .Overflow (Overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add_vec(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] r, input logic c, input logic v, input logic z);
        vec_t t;
        t.op = op; t.a = a; t.b = b; t.r = r; t.c = c; t.v = v; t.z = z;
        vecs.push_back(t);
    endtask

    task automatic chk(input string tag, input int idx, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got=%h expected=%h", tag, idx, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int idx, input logic [7:0] r,
                           input logic c, input logic v, input logic z);
        chk({tag, ".result"},   idx, Result,          r);
        chk({tag, ".carry"},    idx, 8'(Carry),       8'(c));
        chk({tag, ".overflow"}, idx, 8'(Overflow),    8'(v));
        chk({tag, ".zero"},     idx, 8'(Zero),        8'(z));
    endtask

    initial begin
        //       op       A      B      R      C     V     Z
        add_vec(OP_ADD,  8'h0A, 8'h14, 8'h1E, 1'b0, 1'b0, 1'b0);
        add_vec(OP_ADD,  8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
        add_vec(OP_ADD,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
        add_vec(OP_ADD,  8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1);
        add_vec(OP_SUB,  8'h0A, 8'h14, 8'hF6, 1'b1, 1'b0, 1'b0);
        add_vec(OP_SUB,  8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
        add_vec(OP_SUB,  8'h33, 8'h33, 8'h00, 1'b0, 1'b0, 1'b1);
        add_vec(OP_SUB,  8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0);
        add_vec(OP_AND,  8'hAA, 8'h55, 8'h00, 1'b0, 1'b0, 1'b1);
        add_vec(OP_OR,   8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0, 1'b0);
        add_vec(OP_XOR,  8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0, 1'b0);
        add_vec(OP_NOT,  8'hAA, 8'h55, 8'h55, 1'b0, 1'b0, 1'b0);
        add_vec(OP_NOT,  8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        add_vec(OP_NAND, 8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0, 1'b0);
        add_vec(OP_NOR,  8'hAA, 8'h55, 8'h00, 1'b0, 1'b0, 1'b1);
        add_vec(OP_SHL,  8'h0F, 8'h00, 8'h1E, 1'b0, 1'b0, 1'b0);
        add_vec(OP_SHL,  8'h80, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
        add_vec(OP_SHR,  8'h0F, 8'h00, 8'h07, 1'b1, 1'b0, 1'b0);
        add_vec(OP_SHR,  8'h81, 8'h00, 8'h40, 1'b1, 1'b0, 1'b0);
        add_vec(OP_ROR,  8'h0F, 8'h00, 8'h87, 1'b1, 1'b0, 1'b0);
        add_vec(OP_ASR,  8'h81, 8'h00, 8'hC0, 1'b1, 1'b0, 1'b0);
        add_vec(OP_ASR,  8'h7E, 8'h00, 8'h3F, 1'b0, 1'b0, 1'b0);
        add_vec(OP_ROL,  8'h81, 8'h00, 8'h03, 1'b1, 1'b0, 1'b0);
        add_vec(OP_INC,  8'h7F, 8'h00, 8'h80, 1'b0, 1'b1, 1'b0);
        add_vec(OP_INC,  8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
        add_vec(OP_DEC,  8'h00, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
        add_vec(OP_DEC,  8'h80, 8'h00, 8'h7F, 1'b0, 1'b1, 1'b0);
        add_vec(OP_PASS, 8'h5A, 8'hFF, 8'h5A, 1'b0, 1'b0, 1'b0);
        add_vec(OP_PASS, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1);

        // Reset held two cycles with live operands that must be ignored.
        rst = 1'b1; A = 8'hFF; B = 8'h01; Opcode = OP_ADD;
        @(posedge clk); #1;
        chk_all("reset0", 0, 8'h00, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk_all("reset1", 1, 8'h00, 1'b0, 1'b0, 1'b1);

        // Back-to-back: a new opcode every cycle, each checked one edge after it is driven.
        rst = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            Opcode = vecs[i].op; A = vecs[i].a; B = vecs[i].b;
            @(posedge clk); #1;
            chk_all("vec", i, vecs[i].r, vecs[i].c, vecs[i].v, vecs[i].z);
        end

        // Mid-stream reset discards the in-flight ADD overflow result.
        rst = 1'b1; Opcode = OP_ADD; A = 8'h7F; B = 8'h01;
        @(posedge clk); #1;
        chk_all("midrst", 0, 8'h00, 1'b0, 1'b0, 1'b1);
        rst = 1'b0; Opcode = OP_ADD; A = 8'h01; B = 8'h01;
        @(posedge clk); #1;
        chk_all("midrst", 1, 8'h02, 1'b0, 1'b0, 1'b0);

        // Flags are not sticky: carry/overflow set, then cleared by a logic op.
        Opcode = OP_ADD; A = 8'h80; B = 8'h80;
        @(posedge clk); #1;
        chk_all("nosticky", 0, 8'h00, 1'b1, 1'b1, 1'b1);
        Opcode = OP_OR; A = 8'h01; B = 8'h02;
        @(posedge clk); #1;
        chk_all("nosticky", 1, 8'h03, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
